// File: rtl/fetch_buffer.sv
// Instruction fetch stage: owns the fetch PC, issues single-outstanding imem reads
// and queues {instr, pc} toward decode. Optional stall counter: FETCH_STALL_CNT_EN.
module fetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t        state_reg;
  logic          imem_req_reg;
  logic [31:0]   fetch_pc_reg;
  logic [31:0]   addr_reg;
  logic [CW-1:0] count_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc_mem    [DEPTH];

  logic          push;
  logic          pop;
  logic [CW-1:0] count_next;
  logic [31:0]   redirect_aligned;
  logic [31:0]   fetch_pc_inc;

  assign redirect_aligned = redirect_pc & ~32'd3;
  assign fetch_pc_inc     = fetch_pc_reg + 32'd4;
  assign pop              = out_valid && out_ready;
  // Only a live (non-dropped, non-redirected) response reaches the queue.
  assign push             = (state_reg == REQ) && imem_ack && !redirect_valid;
  assign count_next       = count_reg + CW'(push) - CW'(pop);

  assign imem_req  = imem_req_reg;
  assign imem_addr = addr_reg;
  assign out_valid = (count_reg != '0);
  assign out_instr = instr_mem[rd_ptr_reg];
  assign out_pc    = pc_mem[rd_ptr_reg];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      imem_req_reg <= 1'b0;
      fetch_pc_reg <= RESET_PC;
      addr_reg     <= RESET_PC;
    end else begin
      case (state_reg)
        IDLE: begin
          if (redirect_valid) begin
            fetch_pc_reg <= redirect_aligned;
          end else if (count_reg < DEPTH_C) begin
            state_reg    <= REQ;
            imem_req_reg <= 1'b1;
            addr_reg     <= fetch_pc_reg;
          end
        end
        REQ: begin
          if (redirect_valid) begin
            fetch_pc_reg <= redirect_aligned;
            if (imem_ack) begin
              state_reg    <= IDLE;
              imem_req_reg <= 1'b0;
            end else begin
              state_reg <= DROP;
            end
          end else if (imem_ack) begin
            fetch_pc_reg <= fetch_pc_inc;
            if (count_next < DEPTH_C) begin
              addr_reg <= fetch_pc_inc;
            end else begin
              state_reg    <= IDLE;
              imem_req_reg <= 1'b0;
            end
          end
        end
        DROP: begin
          // Old request stays on the bus until its (discarded) response arrives.
          if (redirect_valid) fetch_pc_reg <= redirect_aligned;
          if (imem_ack) begin
            state_reg    <= IDLE;
            imem_req_reg <= 1'b0;
          end
        end
        default: begin
          state_reg    <= IDLE;
          imem_req_reg <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg  <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else if (redirect_valid) begin
      count_reg  <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
    end else begin
      count_reg <= count_next;
      if (pop) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (push) begin
        instr_mem[wr_ptr_reg] <= imem_rdata;
        pc_mem[wr_ptr_reg]    <= addr_reg;
        wr_ptr_reg            <= wr_ptr_reg + AW'(1);
      end
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_reg <= '0;
    end else if (out_ready && !out_valid && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`endif

endmodule
